// File: rtl/archie_pkg.sv
// Shared definitions for the Archimedes core: uploader FSM states and the
// default window of SDRAM that the HPS may read back.
package archie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PREFETCH
  } upl_state_e;

  // RISC OS ROM area, word addressed (SDRAM byte address [25:2])
  localparam logic [23:0] UPL_BASE_DEF = 24'h100000;
  localparam logic [23:0] UPL_SIZE_DEF = 24'h080000;

endpackage

// File: rtl/ram_uploader.sv
// Serves HPS 16-bit ioctl reads out of SDRAM through a one-word line buffer,
// fetching misses and prefetching the next word over Wishbone classic.
module ram_uploader
  import archie_pkg::*;
#(
  parameter logic [23:0] BASE       = UPL_BASE_DEF,
  parameter logic [23:0] SIZE_WORDS = UPL_SIZE_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [23:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack
);

  upl_state_e  state_q;
  logic [31:0] line_q;
  logic [22:0] tag_q, tgt_q;
  logic        valid_q, up_q, pend_q, pf_q, disc_q, wait_q, cyc_q;
  logic [15:0] din_q;
  logic [23:0] adr_q;
  logic [24:1] pend_addr_q;

  logic        unused_addr0;
  logic        up_rise, disc_now, fill;
  logic [24:1] lk_addr;
  logic [22:0] lk_off, lk_tag;
  logic [31:0] lk_line;
  logic        lk_valid, lk_oor, lk_hit, lk_pf;
  logic [15:0] lk_half;
  logic [23:0] lk_adr;

  assign unused_addr0 = ioctl_addr[0];
  assign up_rise  = upload & ~up_q;
  // data of a cycle that straddled an upload edge must never reach the line
  assign disc_now = disc_q | up_rise | ~upload;
  assign fill     = (state_q == ST_PREFETCH) & wb_ack & ~disc_now;

  // Lookup against the line as it will be after this cycle's prefetch fill,
  // so an rd coinciding with (or pending at) the ack sees the new word.
  always_comb begin
    lk_addr  = (state_q == ST_PREFETCH && pend_q) ? pend_addr_q : ioctl_addr[24:1];
    lk_off   = lk_addr[24:2];
    lk_valid = fill | (valid_q & ~up_rise);
    lk_tag   = fill ? tgt_q : tag_q;
    lk_line  = fill ? wb_dat_i : line_q;
    lk_oor   = {1'b0, lk_off} >= SIZE_WORDS;
    lk_hit   = lk_valid && (lk_tag == lk_off) && !lk_oor;
    lk_half  = lk_addr[1] ? lk_line[31:16] : lk_line[15:0];
    lk_pf    = lk_addr[1] && ({1'b0, lk_off} + 24'd1 < SIZE_WORDS);
    lk_adr   = BASE + {1'b0, lk_off};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      line_q      <= '0;
      tag_q       <= '0;
      tgt_q       <= '0;
      valid_q     <= 1'b0;
      up_q        <= 1'b0;
      pend_q      <= 1'b0;
      pf_q        <= 1'b0;
      disc_q      <= 1'b0;
      wait_q      <= 1'b0;
      cyc_q       <= 1'b0;
      din_q       <= '0;
      adr_q       <= '0;
      pend_addr_q <= '0;
    end else begin
      up_q <= upload;
      if (up_rise) valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ioctl_rd) begin
            pf_q <= 1'b0;
            if (lk_oor || (!lk_hit && !upload)) begin
              din_q <= '0;
            end else if (lk_hit) begin
              din_q <= lk_half;
              if (lk_pf && upload) begin
                cyc_q   <= 1'b1;
                adr_q   <= lk_adr + 24'd1;
                tgt_q   <= lk_off + 23'd1;
                disc_q  <= 1'b0;
                state_q <= ST_PREFETCH;
              end
            end else begin
              wait_q      <= 1'b1;
              cyc_q       <= 1'b1;
              adr_q       <= lk_adr;
              tgt_q       <= lk_off;
              pend_addr_q <= lk_addr;
              disc_q      <= 1'b0;
              state_q     <= ST_FETCH;
            end
          end else if (pf_q) begin
            pf_q <= 1'b0;
            if (upload) begin
              cyc_q   <= 1'b1;
              adr_q   <= BASE + {1'b0, tag_q} + 24'd1;
              tgt_q   <= tag_q + 23'd1;
              disc_q  <= 1'b0;
              state_q <= ST_PREFETCH;
            end
          end
        end
        ST_FETCH: begin
          if (!cyc_q) begin
            // issue slot for a miss resolved at a prefetch ack; adr_q is set
            if (upload) begin
              cyc_q  <= 1'b1;
              disc_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (wb_ack) begin
            cyc_q   <= 1'b0;
            wait_q  <= 1'b0;
            state_q <= ST_IDLE;
            if (!disc_now) begin
              line_q  <= wb_dat_i;
              tag_q   <= tgt_q;
              valid_q <= 1'b1;
              din_q   <= pend_addr_q[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
              pf_q    <= pend_addr_q[1] && ({1'b0, tgt_q} + 24'd1 < SIZE_WORDS);
            end
          end
        end
        ST_PREFETCH: begin
          if (ioctl_rd && !pend_q) begin
            pend_q      <= 1'b1;
            pend_addr_q <= ioctl_addr[24:1];
            wait_q      <= 1'b1;
          end
          if (wb_ack) begin
            cyc_q   <= 1'b0;
            pend_q  <= 1'b0;
            state_q <= ST_IDLE;
            if (fill) begin
              line_q  <= wb_dat_i;
              tag_q   <= tgt_q;
              valid_q <= 1'b1;
            end
            if (pend_q || ioctl_rd) begin
              if (lk_oor || (!lk_hit && !upload)) begin
                din_q  <= '0;
                wait_q <= 1'b0;
              end else if (lk_hit) begin
                din_q  <= lk_half;
                wait_q <= 1'b0;
                pf_q   <= lk_pf;
              end else begin
                wait_q      <= 1'b1;
                adr_q       <= lk_adr;
                tgt_q       <= lk_off;
                pend_addr_q <= lk_addr;
                state_q     <= ST_FETCH;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (!upload) begin
        wait_q <= 1'b0;
        pend_q <= 1'b0;
        pf_q   <= 1'b0;
      end
      if (up_rise) pf_q <= 1'b0;
      if ((!upload || up_rise) && cyc_q && !wb_ack) disc_q <= 1'b1;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign wb_cyc     = cyc_q;
  assign wb_stb     = cyc_q;
  assign wb_we      = 1'b0;
  assign wb_sel     = 4'b1111;
  assign wb_cti     = 3'b000;
  assign wb_adr     = adr_q;

endmodule
